// File: rtl/mouse_position_tracker.sv
// PS/2 mouse packet assembler and clamped absolute cursor position tracker.
// Optional inter-byte timeout is built only when MOUSE_PACKET_TIMEOUT_EN is defined.
module mouse_position_tracker #(
  parameter int COLUMNS        = 640,
  parameter int ROWS           = 480,
  parameter int INIT_X         = COLUMNS / 2,
  parameter int INIT_Y         = ROWS / 2,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int XW = $clog2(COLUMNS),
  localparam int YW = $clog2(ROWS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic [XW-1:0] mouse_x_position_o,
  output logic [YW-1:0] mouse_y_position_o,
  output logic          left_button_o,
  output logic          right_button_o,
  output logic          middle_button_o,
  output logic          packet_valid_o,
  output logic          sync_error_o
);

  localparam int MW = (XW > YW) ? XW : YW;
  localparam int SW = ((MW > 9) ? MW : 9) + 2;
  localparam logic signed [SW-1:0] X_MAX = SW'(COLUMNS - 1);
  localparam logic signed [SW-1:0] Y_MAX = SW'(ROWS - 1);

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    UPDATE
  } state_t;

  state_t state, next_state;

  logic       take_b0, take_b1, take_b2, bad_byte, timeout;
  logic [2:0] buttons_q;
  logic       x_sign_q, y_sign_q, x_ovf_q, y_ovf_q;
  logic [7:0] x_mag_q, y_mag_q;
  logic       sync_pending;

  logic signed [8:0]    dx9, dy9;
  logic signed [SW-1:0] dx_ext, dy_ext, x_ext, y_ext, sum_x, sum_y;
  logic [XW-1:0]        new_x;
  logic [YW-1:0]        new_y;

`ifdef MOUSE_PACKET_TIMEOUT_EN
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [IW-1:0] idle_count;
  logic          in_partial;

  assign in_partial = (state == WAIT_B1) || (state == WAIT_B2);
  assign timeout    = in_partial && !rx_valid_i && (idle_count == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      idle_count <= '0;
    end else if (rx_valid_i || !in_partial || timeout) begin
      idle_count <= '0;
    end else begin
      idle_count <= idle_count + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= WAIT_B0;
    end else begin
      state <= next_state;
    end
  end

  // The UPDATE cycle still listens for the next packet's first byte so nothing is dropped.
  always_comb begin
    next_state = state;
    take_b0    = 1'b0;
    take_b1    = 1'b0;
    take_b2    = 1'b0;
    bad_byte   = 1'b0;
    case (state)
      WAIT_B0, UPDATE: begin
        next_state = WAIT_B0;
        if (rx_valid_i) begin
          if (rx_data_i[3]) begin
            take_b0    = 1'b1;
            next_state = WAIT_B1;
          end else begin
            bad_byte = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (rx_valid_i) begin
          take_b1    = 1'b1;
          next_state = WAIT_B2;
        end else if (timeout) begin
          next_state = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (rx_valid_i) begin
          take_b2    = 1'b1;
          next_state = UPDATE;
        end else if (timeout) begin
          next_state = WAIT_B0;
        end
      end
      default: next_state = WAIT_B0;
    endcase
  end

  assign dx9    = {x_sign_q, x_mag_q};
  assign dy9    = {y_sign_q, y_mag_q};
  assign dx_ext = x_ovf_q ? '0 : {{(SW-9){dx9[8]}}, dx9};
  assign dy_ext = y_ovf_q ? '0 : {{(SW-9){dy9[8]}}, dy9};
  assign x_ext  = {{(SW-XW){1'b0}}, mouse_x_position_o};
  assign y_ext  = {{(SW-YW){1'b0}}, mouse_y_position_o};
  assign sum_x  = x_ext + dx_ext;
  assign sum_y  = y_ext - dy_ext;

  always_comb begin
    new_x = sum_x[XW-1:0];
    new_y = sum_y[YW-1:0];
    if (sum_x[SW-1]) begin
      new_x = '0;
    end else if (sum_x > X_MAX) begin
      new_x = XW'(COLUMNS - 1);
    end
    if (sum_y[SW-1]) begin
      new_y = '0;
    end else if (sum_y > Y_MAX) begin
      new_y = YW'(ROWS - 1);
    end
  end

  // An error raised while leaving UPDATE is held back a cycle so it never overlaps packet_valid_o.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mouse_x_position_o <= XW'(INIT_X);
      mouse_y_position_o <= YW'(INIT_Y);
      left_button_o      <= 1'b0;
      right_button_o     <= 1'b0;
      middle_button_o    <= 1'b0;
      packet_valid_o     <= 1'b0;
      sync_error_o       <= 1'b0;
      sync_pending       <= 1'b0;
      buttons_q          <= '0;
      x_sign_q           <= 1'b0;
      y_sign_q           <= 1'b0;
      x_ovf_q            <= 1'b0;
      y_ovf_q            <= 1'b0;
      x_mag_q            <= '0;
      y_mag_q            <= '0;
    end else begin
      if (take_b0) begin
        buttons_q <= rx_data_i[2:0];
        x_sign_q  <= rx_data_i[4];
        y_sign_q  <= rx_data_i[5];
        x_ovf_q   <= rx_data_i[6];
        y_ovf_q   <= rx_data_i[7];
      end
      if (take_b1) begin
        x_mag_q <= rx_data_i;
      end
      if (take_b2) begin
        y_mag_q <= rx_data_i;
      end
      packet_valid_o <= (state == UPDATE);
      if (state == UPDATE) begin
        mouse_x_position_o <= new_x;
        mouse_y_position_o <= new_y;
        left_button_o      <= buttons_q[0];
        right_button_o     <= buttons_q[1];
        middle_button_o    <= buttons_q[2];
        sync_error_o       <= 1'b0;
        sync_pending       <= bad_byte | timeout;
      end else begin
        sync_error_o <= bad_byte | timeout | sync_pending;
        sync_pending <= 1'b0;
      end
    end
  end

endmodule
